move_key_debouncer: RTL
=======================

Name: move_key_debouncer

Overview:
- Consumes the 60 Hz slow clock (Clk60) produced by the clock divider and uses it as a sampling tick for the four move buttons (Up, Down, Left, Right).
- Debounces each button, generates exactly one move request per clean press, and presents it to the 2048 game FSM over a valid/ack handshake.
- Sits between the board push-buttons / clock divider and the game-logic controller. All logic runs in the 100 MHz Clk domain; Clk60 is never used as a clock.

Parameters:
- NBTN, 4, number of buttons; fixed at 4 for 2-bit direction encoding.
- STABLE_TICKS, 3, consecutive agreeing 60 Hz samples needed to accept a press or release (about 50 ms). Legal range is 2..15.
- CNT_W, 4, width of the per-button tick counter; must hold STABLE_TICKS.
- REPEAT_TICKS, 15, ticks between auto-repeats (used only with the optional feature).

Ports:
- Clk, in, 1: 100 MHz system clock.
- Reset, in, 1: asynchronous, active-high.
- Clk60, in, 1: 60 Hz square wave from the divider, treated as data.
- BtnRaw, in, 4: raw buttons. Bit 0 = Up, 1 = Down, 2 = Left, 3 = Right.
- MoveValid, out, 1: a move request is pending.
- MoveDir, out, 2: pending direction. 0 = Up, 1 = Down, 2 = Left, 3 = Right.
- MoveAck, in, 1: the game FSM accepts the pending move.
- BtnLevel, out, 4: debounced button levels (HELD or RELEASE_CNT = 1).

Behaviour:
- **Synchronisers.** Clk60 and each BtnRaw bit pass through 2-flop synchronisers. Tick = rising edge of the synchronised Clk60 (registered compare), one Clk cycle wide. The tick fires 3 Clk cycles after the Clk60 rise. The FSMs and counters change state only on tick cycles.
- **Per-button FSM.** States are IDLE, PRESS_CNT, HELD, RELEASE_CNT; cnt is CNT_W bits.
  - IDLE: on tick with sample = 1, go to PRESS_CNT with cnt = 1.
  - PRESS_CNT: on tick with sample = 0, go to IDLE with cnt = 0. With sample = 1 and cnt == STABLE_TICKS-1, go to HELD and assert the press event. Otherwise cnt++.
  - HELD: on tick with sample = 0, go to RELEASE_CNT with cnt = 1.
  - RELEASE_CNT: on tick with sample = 1, go to HELD. With sample = 0 and cnt == STABLE_TICKS-1, go to IDLE. Otherwise cnt++.
  - The press event is a one-cycle registered pulse, asserted the cycle after the qualifying tick.
- **Arbiter and output register.**
  - accept = press event present AND (MoveValid == 0 OR MoveAck == 1).
  - On accept: the next cycle has MoveValid = 1 and MoveDir = highest-priority event. Priority is Up > Down > Left > Right.
  - MoveAck with MoveValid = 1 and no event: MoveValid drops to 0 next cycle.
  - Simultaneous ack and event: MoveValid stays 1 and MoveDir updates to the new direction.
  - Events arriving while MoveValid = 1 with no ack are dropped, never queued. Lower-priority simultaneous events are also dropped.
  - MoveAck while MoveValid = 0 is ignored.
  - MoveDir is stable while MoveValid = 1.
- **Reset.** All FSMs go to IDLE, counters to 0, synchronisers to 0, MoveValid = 0, MoveDir = 0, BtnLevel = 0.
  - A button held through reset deassertion must debounce afresh and produce exactly one move after STABLE_TICKS ticks.
  - Reset mid-handshake discards the pending move.
- **Clk60 stuck.** If Clk60 is stuck at 0 or 1, there are no ticks, so no state changes and no moves.

Optional Feature:
- Macro: MOVE_AUTO_REPEAT_EN.
- **Defined:** each button in HELD keeps a repeat counter that resets on entering HELD. After REPEAT_TICKS ticks it emits another press event and restarts. Leaving HELD clears the counter. Repeat events follow the same arbitration and drop rules.
- **Undefined:** there is no repeat logic or counter. Exactly one event per press.

Decomposition:
- Package move_key_pkg holds:
  - direction constants DIR_UP/DOWN/LEFT/RIGHT (2'd0..2'd3);
  - the debounce state encoding (2 bits);
  - the default STABLE_TICKS and REPEAT_TICKS values.
- Sub-module btn_debounce_fsm, instantiated NBTN times, contains the per-button synchroniser, FSM, counter and optional repeat counter. Its outputs are level and press event.
- The top level holds the Clk60 synchroniser, the edge detect, the arbiter and the handshake register.

Test Plan:
All scenarios use a simulated Clk60 period of 40 Clk cycles and STABLE_TICKS = 3.
- **Clean press.** Up held for 10 ticks, MoveAck pulsed 5 cycles after MoveValid rises. Expect exactly one MoveValid with MoveDir = 0, and MoveValid falls 1 cycle after the ack. No further moves.
- **Bounce rejection.** Left toggles on alternate ticks for 8 ticks, then holds steadily. Expect no move during the toggling, then one move with MoveDir = 2 on the 3rd stable tick + 1 cycle.
- **Simultaneous press.** Down and Right rise in the same cycle. Expect MoveDir = 1 and the Right event dropped.
- **Pending drop / same-cycle ack.**
  - Part 1: with Up pending and unacked, a Right press qualifies. Expect MoveDir to stay 0.
  - Part 2: repeat with MoveAck asserted on the event cycle. Expect MoveValid to stay 1 and MoveDir to change to 3.
- **Reset.**
  - Part 1: assert Reset while MoveValid = 1. Expect MoveValid = 0 and MoveDir = 0 immediately.
  - Part 2: with Down held across reset release, expect one move with MoveDir = 1 after 3 ticks.
- **MOVE_AUTO_REPEAT_EN, REPEAT_TICKS = 4.** Hold Up for 20 ticks with an immediate ack each time. Expect moves at tick 3, then every 4 ticks (5 moves total). With the macro undefined, expect 1 move.

Source files
------------

// File: rtl/move_key_pkg.sv
// move_key_pkg: shared direction codes, debounce state encoding and default timing for move_key_debouncer.
package move_key_pkg;
  localparam logic [1:0] DIR_UP = 2'd0;
  localparam logic [1:0] DIR_DOWN = 2'd1;
  localparam logic [1:0] DIR_LEFT = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;
  localparam int STABLE_TICKS_DEF = 3;
  localparam int CNT_W_DEF = 4;
  localparam int REPEAT_TICKS_DEF = 15;
  typedef enum logic [1:0] {IDLE, PRESS_CNT, HELD, RELEASE_CNT} deb_state_e;
  function automatic logic [1:0] prio_dir(input logic [3:0] evt);
    return evt[0] ? DIR_UP : evt[1] ? DIR_DOWN : evt[2] ? DIR_LEFT : DIR_RIGHT;
  endfunction
endpackage

// File: rtl/move_key_debouncer_btn.sv
// btn_debounce_fsm: per-button synchroniser, tick-driven debounce FSM and press pulse.
// Auto-repeat while held is built only when MOVE_AUTO_REPEAT_EN is defined.
module btn_debounce_fsm import move_key_pkg::*; #(
  parameter int STABLE_TICKS = STABLE_TICKS_DEF,
  parameter int CNT_W = CNT_W_DEF
`ifdef MOVE_AUTO_REPEAT_EN
  , parameter int REPEAT_TICKS = REPEAT_TICKS_DEF
`endif
) (
  input  logic Clk,
  input  logic Reset,
  input  logic tick,
  input  logic btn_raw,
  output logic level,
  output logic press_evt
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_TICKS - 1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  logic sync_q, smp_q, press_q, press_d, fsm_evt, rpt_evt;
  deb_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    fsm_evt = 1'b0;
    if (tick)
      case (state_q)
        IDLE: if (smp_q) begin state_d = PRESS_CNT; cnt_d = ONE; end
        PRESS_CNT:
          if (!smp_q) begin state_d = IDLE; cnt_d = '0; end
          else if (cnt_q == LAST) begin state_d = HELD; cnt_d = '0; fsm_evt = 1'b1; end
          else cnt_d = cnt_q + ONE;
        HELD: if (!smp_q) begin state_d = RELEASE_CNT; cnt_d = ONE; end
        RELEASE_CNT:
          if (smp_q) begin state_d = HELD; cnt_d = '0; end
          else if (cnt_q == LAST) begin state_d = IDLE; cnt_d = '0; end
          else cnt_d = cnt_q + ONE;
        default: state_d = IDLE;
      endcase
    press_d = fsm_evt | rpt_evt;
  end
`ifdef MOVE_AUTO_REPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_TICKS + 1);
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_TICKS - 1);
  logic [RPT_W-1:0] rpt_q, rpt_d;
  // Counter lives only while staying in HELD; entering or leaving clears it.
  always_comb begin
    rpt_d = '0;
    rpt_evt = 1'b0;
    if (state_q == HELD && state_d == HELD) begin
      rpt_evt = tick && rpt_q == RPT_LAST;
      rpt_d = rpt_evt ? '0 : tick ? rpt_q + RPT_W'(1) : rpt_q;
    end
  end
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) rpt_q <= '0;
    else rpt_q <= rpt_d;
`else
  assign rpt_evt = 1'b0;
`endif
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      sync_q <= 1'b0;
      smp_q <= 1'b0;
      state_q <= IDLE;
      cnt_q <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q <= btn_raw;
      smp_q <= sync_q;
      state_q <= state_d;
      cnt_q <= cnt_d;
      press_q <= press_d;
    end
  assign press_evt = press_q;
  assign level = state_q == HELD || state_q == RELEASE_CNT;
endmodule

// File: rtl/move_key_debouncer.sv
// move_key_debouncer: 60 Hz tick extraction, per-button debounce, priority arbiter and valid/ack move register.
// Define MOVE_AUTO_REPEAT_EN to add held-button auto-repeat.
module move_key_debouncer import move_key_pkg::*; #(
  parameter int NBTN = 4,
  parameter int STABLE_TICKS = STABLE_TICKS_DEF,
  parameter int CNT_W = CNT_W_DEF
`ifdef MOVE_AUTO_REPEAT_EN
  , parameter int REPEAT_TICKS = REPEAT_TICKS_DEF
`endif
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Clk60,
  input  logic [NBTN-1:0] BtnRaw,
  output logic            MoveValid,
  output logic [1:0]      MoveDir,
  input  logic            MoveAck,
  output logic [NBTN-1:0] BtnLevel
);
  logic c60_s1_q, c60_s2_q, c60_s3_q, tick_q, tick_d, valid_q, valid_d, accept;
  logic [1:0] dir_q, dir_d;
  logic [NBTN-1:0] evt;
  for (genvar i = 0; i < NBTN; i++) begin : g_btn
    btn_debounce_fsm #(
      .STABLE_TICKS(STABLE_TICKS),
      .CNT_W(CNT_W)
`ifdef MOVE_AUTO_REPEAT_EN
      , .REPEAT_TICKS(REPEAT_TICKS)
`endif
    ) u_btn (
      .Clk(Clk),
      .Reset(Reset),
      .tick(tick_q),
      .btn_raw(BtnRaw[i]),
      .level(BtnLevel[i]),
      .press_evt(evt[i])
    );
  end
  // Events that cannot be accepted this cycle are dropped, never queued.
  always_comb begin
    tick_d = c60_s2_q & ~c60_s3_q;
    accept = |evt & (~valid_q | MoveAck);
    valid_d = accept ? 1'b1 : MoveAck ? 1'b0 : valid_q;
    dir_d = accept ? prio_dir(evt) : dir_q;
  end
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      c60_s1_q <= 1'b0;
      c60_s2_q <= 1'b0;
      c60_s3_q <= 1'b0;
      tick_q <= 1'b0;
      valid_q <= 1'b0;
      dir_q <= DIR_UP;
    end else begin
      c60_s1_q <= Clk60;
      c60_s2_q <= c60_s1_q;
      c60_s3_q <= c60_s2_q;
      tick_q <= tick_d;
      valid_q <= valid_d;
      dir_q <= dir_d;
    end
  assign MoveValid = valid_q;
  assign MoveDir = dir_q;
endmodule
